muldiv_iterative_unit: RTL and testbench
========================================

// Module: muldiv_iterative_unit
// PURPOSE
//  Multi-cycle HI/LO arithmetic responder for the execute stage: accepts one MULT/DIV-family
//  request, computes it bit-serially (shift-add / restoring divide) and returns {hi,lo}.
//  Sits behind the execute-stage mul/div wrapper; its busy drives the stage's wait_result stall,
//  its done/hi_out/lo_out feed dest_hi_data/dest_lo_data.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; only 32 is verified
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  reset        in   1        synchronous, active-high reset
//  start        in   1        request valid; sampled only when accept condition holds
//  op           in   4        0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MADD,6 MADDU,7 MSUB,8 MSUBU; others = NONE
//  rs, rt       in   WIDTH    operands (rs = multiplicand/dividend, rt = multiplier/divisor)
//  hi_in, lo_in in   WIDTH    accumulator for MADD*/MSUB*, latched with the request
//  clear        in   1        pipeline bubble: abort current operation
//  hold_result  in   1        pipeline stall: keep result in DONE, refuse new requests
//  busy         out  1        state is RUN or FIX (combinational from state)
//  done         out  1        registered; 1 while state is DONE
//  hi_out       out  WIDTH    registered result high word
//  lo_out       out  WIDTH    registered result low word
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, hi_out=lo_out=0, counter=0; reset wins over all inputs.
//  States IDLE, RUN, FIX, DONE.
//  Accept: start=1 && op!=NONE && (IDLE || (DONE && !hold_result)) && !clear -> latch op, rs, rt,
//   hi_in, lo_in; load counter=WIDTH-1; -> RUN. start while RUN/FIX or DONE+hold is ignored.
//  RUN: one iteration per edge on |rs|,|rt| (signed ops) or raw (unsigned); at counter==0 -> FIX.
//  FIX (1 cycle): sign correction, accumulate, divide-by-zero override; write hi_out/lo_out; -> DONE.
//  DONE: done=1, results stable. hold_result=1 -> stay. Else accepted start -> RUN, else -> IDLE.
//  Latency: start accepted at edge E0; iterations E1..E32; FIX->DONE at E33; done=1 in cycle
//   after E33 (34 cycles incl. request cycle); busy=1 for exactly 33 cycles.
//  Arithmetic: MULT/MULTU {hi,lo}=64-bit product. MADD*: {hi_in,lo_in}+product; MSUB*:
//   {hi_in,lo_in}-product; mod 2^64, no overflow flag. DIV*: lo=quotient, hi=remainder;
//   signed: quotient truncates toward zero, remainder takes sign of rs.
//  Boundaries: divisor 0 (DIV or DIVU) -> lo=0xFFFFFFFF, hi=rs. DIV 0x80000000/-1 ->
//   lo=0x80000000, hi=0. Product of -2^31*-2^31 exact (0x40000000_00000000).
//  clear=1 (any state): next state IDLE, done=0, hi_out/lo_out keep prior value; no start
//   accepted that edge. clear and hold_result both 1: clear wins.
//  hi_out/lo_out change only at FIX->DONE; never glitch during RUN.
// TESTING
//  MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; busy 33 cyc, done on 34th.
//  MULT rs=-3 rt=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  DIVU rs=7 rt=0 -> lo=0xFFFFFFFF hi=7; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  MADD hi_in=0 lo_in=0xFFFFFFFF rs=1 rt=1 -> hi=1 lo=0; MSUBU hi_in=lo_in=0 rs=1 rt=1 ->
//   hi=lo=0xFFFFFFFF.
//  clear at 10th RUN cycle -> IDLE next cycle, busy=0, done=0, hi/lo unchanged; start with new
//   op during RUN ignored (result matches first op); reset mid-RUN -> all outputs 0.
//  In DONE with hold_result=1 for 5 cycles and start=1 -> done stays 1, results stable, no
//   restart; drop hold with start=1 -> RUN next edge; drop hold, start=0 -> IDLE.

Source files
------------

// File: rtl/muldiv_iterative_unit.sv
// Bit-serial HI/LO engine: shift-add multiply (with optional accumulate) and restoring divide.
// Latency: start accepted at E0, WIDTH iterations, one FIX edge; done the cycle after E(WIDTH+1).
// Backpressure: busy stalls the stage; hold_result parks the result in DONE and refuses new starts.
module muldiv_iterative_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             clear,
    input  logic             hold_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE_C    = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [W2-1:0]    ONE_2W   = W2'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               accept;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   work_hi_q, work_lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [W2-1:0]      acc_q;
    logic [WIDTH-1:0]   rs_q;
    logic               div_q, madd_q, msub_q;
    logic               neg_prod_q, neg_rem_q, div_zero_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               op_valid, op_signed, op_div, op_madd, op_msub;
    logic [WIDTH-1:0]   rs_mag, rt_mag;

    always_comb begin
        op_valid  = 1'b1;
        op_signed = 1'b0;
        op_div    = 1'b0;
        op_madd   = 1'b0;
        op_msub   = 1'b0;
        case (op)
            4'd1: op_signed = 1'b1;
            4'd2: op_valid  = 1'b1;
            4'd3: begin op_signed = 1'b1; op_div = 1'b1; end
            4'd4: op_div = 1'b1;
            4'd5: begin op_signed = 1'b1; op_madd = 1'b1; end
            4'd6: op_madd = 1'b1;
            4'd7: begin op_signed = 1'b1; op_msub = 1'b1; end
            4'd8: op_msub = 1'b1;
            default: op_valid = 1'b0;
        endcase
    end

    // Iterations run on magnitudes; signs are restored in FIX.
    assign rs_mag = (op_signed && rs[WIDTH-1]) ? (~rs + ONE_W) : rs;
    assign rt_mag = (op_signed && rt[WIDTH-1]) ? (~rt + ONE_W) : rt;

    always_comb begin
        accept = start && op_valid && !clear &&
                 ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !hold_result));
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                if (accept)            state_d = ST_RUN;
                else if (!hold_result) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    always_comb begin
        mul_addend = work_lo_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, work_hi_q} + {1'b0, mul_addend};
        div_shift  = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd_q};
        if (div_q) begin
            // Partial remainder stays below the divisor, so the difference fits WIDTH+1 bits signed.
            iter_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            iter_lo = {work_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
    end

    logic [W2-1:0]    prod_mag, prod_s, mul_res, fix_res;
    logic [WIDTH-1:0] quo_s, rem_s;

    always_comb begin
        prod_mag = {work_hi_q, work_lo_q};
        prod_s   = neg_prod_q ? (~prod_mag + ONE_2W) : prod_mag;
        if (madd_q)      mul_res = acc_q + prod_s;
        else if (msub_q) mul_res = acc_q - prod_s;
        else             mul_res = prod_s;
        quo_s = neg_prod_q ? (~work_lo_q + ONE_W) : work_lo_q;
        rem_s = neg_rem_q  ? (~work_hi_q + ONE_W) : work_hi_q;
        if (!div_q)          fix_res = mul_res;
        else if (div_zero_q) fix_res = {rs_q, {WIDTH{1'b1}}};
        else                 fix_res = {rem_s, quo_s};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rs_q       <= '0;
            div_q      <= 1'b0;
            madd_q     <= 1'b0;
            msub_q     <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
            if (accept) begin
                cnt_q      <= CNT_LOAD;
                work_hi_q  <= '0;
                work_lo_q  <= op_div ? rs_mag : rt_mag;
                opnd_q     <= op_div ? rt_mag : rs_mag;
                acc_q      <= {hi_in, lo_in};
                rs_q       <= rs;
                div_q      <= op_div;
                madd_q     <= op_madd;
                msub_q     <= op_msub;
                neg_prod_q <= op_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                neg_rem_q  <= op_signed & rs[WIDTH-1];
                div_zero_q <= (rt == '0);
            end else if (state_q == ST_RUN) begin
                work_hi_q <= iter_hi;
                work_lo_q <= iter_lo;
                if (cnt_q != '0) cnt_q <= cnt_q - ONE_C;
            end
            // Results move only on FIX->DONE, so an aborted FIX leaves the prior result visible.
            if ((state_q == ST_FIX) && !clear) begin
                hi_q <= fix_res[W2-1:WIDTH];
                lo_q <= fix_res[WIDTH-1:0];
            end
        end
    end

    assign busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Scoreboarded bench for muldiv_iterative_unit: spec vectors, control corner cases, random ops.
module tb_muldiv_iterative_unit;

    logic        clk = 1'b0;
    logic        reset, start, clear, hold_result;
    logic [3:0]  op;
    logic [31:0] rs, rt, hi_in, lo_in;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_exp = 64'd0;
    logic        done_prev = 1'b0;

    muldiv_iterative_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .hi_in(hi_in), .lo_in(lo_in), .clear(clear), .hold_result(hold_result),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign- or zero-extended operands.
    function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [31:0] a32,
                                              input logic [31:0] b32, input logic [31:0] h,
                                              input logic [31:0] l);
        logic signed [63:0] a, b, q, r;
        logic [63:0] acc;
        bit sgn;
        sgn = (o == 4'd1) || (o == 4'd3) || (o == 4'd5) || (o == 4'd7);
        a   = sgn ? {{32{a32[31]}}, a32} : {32'd0, a32};
        b   = sgn ? {{32{b32[31]}}, b32} : {32'd0, b32};
        acc = {h, l};
        case (o)
            4'd1, 4'd2: return a * b;
            4'd5, 4'd6: return acc + a * b;
            4'd7, 4'd8: return acc - a * b;
            4'd3, 4'd4: begin
                if (b32 == 32'd0) return {a32, 32'hFFFF_FFFF};
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops on each rising done, and requires the outputs to equal the last result every cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            cur_exp   = 64'd0;
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi_out, lo_out);
                end else begin
                    cur_exp = exp_q.pop_front();
                end
            end
            check("result", {hi_out, lo_out}, cur_exp);
            done_prev = done;
        end
    end

    // Call at a negedge with the unit in IDLE or DONE (no hold); returns at the negedge showing done.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] h, input logic [31:0] l, input logic [63:0] e,
                          input int poke);
        int cyc, bsy;
        bit got;
        op = o; rs = a; rt = b; hi_in = h; lo_in = l; start = 1'b1;
        exp_q.push_back(e);
        cyc = 0; bsy = 0; got = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 100) begin
            if (done) begin got = 1'b1; break; end
            if (busy) bsy++;
            cyc++;
            if (cyc == poke) begin
                start = 1'b1; op = 4'd4;
                rs = $urandom; rt = $urandom; hi_in = $urandom; lo_in = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("busy_cycles", 64'(bsy), 64'd33);
        check("done_latency", 64'(cyc), 64'd33);
    endtask

    task automatic wait_done();
        int cyc;
        bit got;
        cyc = 0; got = 1'b0;
        while (cyc < 100) begin
            if (done) begin got = 1'b1; break; end
            cyc++;
            @(negedge clk);
        end
        check("wait_done", 64'(got), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, h, l;
        logic [3:0]  o;
        reset = 1'b1; start = 1'b0; clear = 1'b0; hold_result = 1'b0;
        op = 4'd0; rs = 32'd0; rt = 32'd0; hi_in = 32'd0; lo_in = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi_out, lo_out}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'hFFFF_FFFE_0000_0001, 0);
        run_op(4'd1, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op(4'd4, 32'd7, 32'd0, 32'd0, 32'd0, 64'h0000_0007_FFFF_FFFF, 0);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 64'h0000_0000_8000_0000, 0);
        run_op(4'd5, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0000, 0);
        run_op(4'd8, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op(4'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 64'h4000_0000_0000_0000, 0);
        run_op(4'd3, 32'h0000_0005, 32'd0, 32'd0, 32'd0, 64'h0000_0005_FFFF_FFFF, 0);

        // Codes outside 1..8 behave as NONE; from DONE the unit falls back to IDLE.
        for (int i = 0; i < 3; i++) begin
            op = (i == 0) ? 4'd0 : ((i == 1) ? 4'd9 : 4'd15);
            rs = $urandom; rt = $urandom; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("none_op_busy", 64'(busy), 64'd0);
            check("none_op_done", 64'(done), 64'd0);
        end

        // New start during RUN with different operands must be ignored.
        a = $urandom; b = $urandom;
        run_op(4'd1, a, b, 32'd0, 32'd0, ref_model(4'd1, a, b, 32'd0, 32'd0), 5);

        // Clear in the 10th RUN cycle, with a competing start that edge.
        a = $urandom; b = $urandom;
        op = 4'd7; rs = a; rt = b; hi_in = $urandom; lo_in = $urandom; start = 1'b1;
        exp_q.push_back(64'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clear = 1'b1; start = 1'b1; op = 4'd2;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        void'(exp_q.pop_back());
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_done", 64'(done), 64'd0);
        @(negedge clk);
        check("clear_no_accept", 64'(busy), 64'd0);

        // Hold in DONE with start asserted, then release with start still high.
        a = $urandom; b = $urandom;
        run_op(4'd6, a, b, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(4'd6, a, b, 32'h1234_5678, 32'h9ABC_DEF0), 0);
        a = pick(); b = pick();
        hold_result = 1'b1; start = 1'b1; op = 4'd3; rs = a; rt = b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_done", 64'(done), 64'd1);
            check("hold_busy", 64'(busy), 64'd0);
        end
        hold_result = 1'b0;
        exp_q.push_back(ref_model(4'd3, a, b, 32'd0, 32'd0));
        @(negedge clk);
        start = 1'b0;
        check("release_busy", 64'(busy), 64'd1);
        check("release_done", 64'(done), 64'd0);
        wait_done();
        @(negedge clk);
        check("idle_after_done", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // Clear and hold together in DONE: clear wins.
        a = $urandom; b = $urandom;
        run_op(4'd2, a, b, 32'd0, 32'd0, ref_model(4'd2, a, b, 32'd0, 32'd0), 0);
        hold_result = 1'b1; clear = 1'b1;
        @(negedge clk);
        hold_result = 1'b0; clear = 1'b0;
        check("clear_hold_done", 64'(done), 64'd0);
        check("clear_hold_busy", 64'(busy), 64'd0);

        // Reset mid-RUN.
        op = 4'd4; rs = $urandom; rt = 32'd3; start = 1'b1;
        exp_q.push_back(64'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(done), 64'd0);
        check("rst_run_hilo", {hi_out, lo_out}, 64'd0);
        void'(exp_q.pop_back());
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(1, 8));
            a = pick(); b = pick(); h = $urandom; l = $urandom;
            run_op(o, a, b, h, l, ref_model(o, a, b, h, l), 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
